// File: rtl/tt_um_accelshark_psg_mixer.sv
// Four-voice stereo PSG mixer: one voice multiply-accumulate per cycle.
// Optional master gain with saturation is enabled by defining MIXER_GAIN_EN.
module tt_um_accelshark_psg_mixer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        strobe,
    input  logic [31:0] voice,
    input  logic [15:0] vol,
    input  logic [7:0]  pan,
`ifdef MIXER_GAIN_EN
    input  logic [1:0]  gain,
`endif
    output logic [15:0] mix_l,
    output logic [15:0] mix_r,
    output logic        valid,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_voice;
    logic [15:0] r_vol;
    logic [7:0]  r_pan;
    logic [13:0] r_acc_l;
    logic [13:0] r_acc_r;
    logic [15:0] r_mix_l;
    logic [15:0] r_mix_r;
    logic        r_valid;
    logic        r_overrun;
`ifdef MIXER_GAIN_EN
    logic [1:0]  r_gain;
`endif

    logic [7:0]  w_voice_k;
    logic [3:0]  w_vol_k;
    logic        w_pan_l;
    logic        w_pan_r;
    logic [11:0] w_product;
    logic [13:0] w_add_l;
    logic [13:0] w_add_r;
    logic [15:0] w_out_l;
    logic [15:0] w_out_r;

    // Select the snapshot fields of the voice addressed by the index.
    always_comb begin
        w_voice_k = 8'd0;
        w_vol_k   = 4'd0;
        w_pan_l   = 1'b0;
        w_pan_r   = 1'b0;
        unique case (r_idx)
            2'd0: begin
                w_voice_k = r_voice[7:0];
                w_vol_k   = r_vol[3:0];
                w_pan_l   = r_pan[0];
                w_pan_r   = r_pan[1];
            end
            2'd1: begin
                w_voice_k = r_voice[15:8];
                w_vol_k   = r_vol[7:4];
                w_pan_l   = r_pan[2];
                w_pan_r   = r_pan[3];
            end
            2'd2: begin
                w_voice_k = r_voice[23:16];
                w_vol_k   = r_vol[11:8];
                w_pan_l   = r_pan[4];
                w_pan_r   = r_pan[5];
            end
            2'd3: begin
                w_voice_k = r_voice[31:24];
                w_vol_k   = r_vol[15:12];
                w_pan_l   = r_pan[6];
                w_pan_r   = r_pan[7];
            end
        endcase
    end

    assign w_product = {4'b0000, w_voice_k} * {8'h00, w_vol_k};
    assign w_add_l   = w_pan_l ? {2'b00, w_product} : 14'd0;
    assign w_add_r   = w_pan_r ? {2'b00, w_product} : 14'd0;

`ifdef MIXER_GAIN_EN
    logic [16:0] w_scaled_l;
    logic [16:0] w_scaled_r;

    // Apply the master shift; anything past 16 bits clips to full scale.
    always_comb begin
        w_scaled_l = {3'b000, r_acc_l} << r_gain;
        w_scaled_r = {3'b000, r_acc_r} << r_gain;
        w_out_l    = w_scaled_l[16] ? 16'hFFFF : w_scaled_l[15:0];
        w_out_r    = w_scaled_r[16] ? 16'hFFFF : w_scaled_r[15:0];
    end
`else
    // Fixed x4 scaling; the largest sum (15300) still fits 16 bits.
    always_comb begin
        w_out_l = {r_acc_l, 2'b00};
        w_out_r = {r_acc_r, 2'b00};
    end
`endif

    // Sequencer: snapshot, four accumulate cycles, then publish the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_voice   <= 32'd0;
            r_vol     <= 16'd0;
            r_pan     <= 8'd0;
            r_acc_l   <= 14'd0;
            r_acc_r   <= 14'd0;
            r_mix_l   <= 16'd0;
            r_mix_r   <= 16'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef MIXER_GAIN_EN
            r_gain    <= 2'd0;
`endif
        end else if (!ena) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (strobe) begin
                        r_voice <= voice;
                        r_vol   <= vol;
                        r_pan   <= pan;
`ifdef MIXER_GAIN_EN
                        r_gain  <= gain;
`endif
                        r_acc_l <= 14'd0;
                        r_acc_r <= 14'd0;
                        r_idx   <= 2'd0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_valid <= 1'b0;
                    if (strobe) begin
                        r_overrun <= 1'b1;
                    end
                    r_acc_l <= r_acc_l + w_add_l;
                    r_acc_r <= r_acc_r + w_add_r;
                    if (r_idx == 2'd3) begin
                        r_idx   <= 2'd0;
                        r_state <= S_OUTPUT;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                S_OUTPUT: begin
                    if (strobe) begin
                        r_overrun <= 1'b1;
                    end
                    r_mix_l <= w_out_l;
                    r_mix_r <= w_out_r;
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_idx   <= 2'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mix_l   = r_mix_l;
    assign mix_r   = r_mix_r;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule
